fetch_redirect_ctrl: RTL and testbench

Fetch controller that sequences ICache requests for the frontend. It owns the fetch PC and arbitrates the redirect sources by fixed priority: exception, eret, mispredict, replay, branch prediction. It limits the number of in-flight ICache requests, generates kill_s1/kill_s2, and filters stale responses. It sits between the ICache request port and the predictor/instruction-queue logic, and replaces ad-hoc next-PC selection.

---
 rtl/fetch_redirect_ctrl.sv | 84 ++++++++
 tb/tb_fetch_redirect_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: owns the fetch PC, arbitrates redirects, bounds in-flight ICache requests
module fetch_redirect_ctrl #(
   parameter int unsigned VLEN             = 64,
   parameter int unsigned FETCH_ALIGN_BITS = 2,
   parameter int unsigned MAX_OUTSTANDING  = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [VLEN-1:0] boot_addr_i,
   input  logic            ex_valid_i,
   input  logic [VLEN-1:0] trap_vector_base_i,
   input  logic            eret_i,
   input  logic [VLEN-1:0] epc_i,
   input  logic            mispredict_i,
   input  logic [VLEN-1:0] mispredict_target_i,
   input  logic            replay_i,
   input  logic [VLEN-1:0] replay_addr_i,
   input  logic            bp_valid_i,
   input  logic [VLEN-1:0] bp_target_i,
   input  logic            halt_i,
   input  logic            iq_ready_i,
   input  logic            icache_ready_i,
   input  logic            icache_rsp_valid_i,
   output logic            icache_req_o,
   output logic [VLEN-1:0] icache_vaddr_o,
   output logic            kill_s1_o,
   output logic            kill_s2_o,
   output logic            rsp_accept_o,
   output logic [1:0]      state_o
);
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, REDIR = 2'd2, HALT = 2'd3} state_e;
   localparam int unsigned BW = VLEN - FETCH_ALIGN_BITS;
   state_e          state_q, state_d;
   logic [VLEN-1:0] pc_q, pc_d, hard_target, pc_seq;
   logic [2:0]      cnt_q, cnt_d;
   logic            hard, bp_take, accept;
   assign hard           = (state_q != BOOT) & (ex_valid_i | eret_i | mispredict_i | replay_i);
   assign hard_target    = ex_valid_i ? trap_vector_base_i : eret_i ? epc_i :
                           mispredict_i ? mispredict_target_i : replay_addr_i;
   assign rsp_accept_o   = icache_rsp_valid_i & (cnt_q != 3'd0) & ~hard & ((state_q == RUN) | (state_q == HALT));
   assign bp_take        = bp_valid_i & rsp_accept_o;
   assign icache_req_o   = (state_q == RUN) & iq_ready_i & ~halt_i & (cnt_q < 3'(MAX_OUTSTANDING)) & ~hard & ~bp_take;
   assign accept         = icache_req_o & icache_ready_i;
   assign kill_s1_o      = hard;
   assign kill_s2_o      = hard | bp_take;
   assign icache_vaddr_o = pc_q;
   assign state_o        = state_q;
   assign pc_seq         = {pc_q[VLEN-1:FETCH_ALIGN_BITS] + {{(BW-1){1'b0}}, 1'b1}, {FETCH_ALIGN_BITS{1'b0}}};
   // next state, PC and outstanding count; hard redirects override everything, then predictions
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q + {2'b00, accept} - {2'b00, rsp_accept_o};
      if (accept) pc_d = pc_seq;
      case (state_q)
         BOOT:    state_d = RUN;
         REDIR:   state_d = halt_i ? HALT : RUN;
         default: state_d = halt_i ? HALT : RUN;
      endcase
      if (state_q == BOOT) begin
         pc_d  = boot_addr_i;
         cnt_d = 3'd0;
      end else if (hard) begin
         state_d = REDIR;
         pc_d    = hard_target;
         cnt_d   = 3'd0;
      end else if (bp_take) begin
         pc_d  = bp_target_i;
         cnt_d = 3'd0;
      end
   end
   // state registers with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= BOOT;
         pc_q    <= '0;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed checks of fetch sequencing, redirects, halt and reset
module tb_fetch_redirect_ctrl;
   logic        clk_i = 1'b0, rst_ni;
   logic [63:0] boot_addr_i, trap_vector_base_i, epc_i, mispredict_target_i, replay_addr_i, bp_target_i;
   logic        ex_valid_i, eret_i, mispredict_i, replay_i, bp_valid_i, halt_i, iq_ready_i;
   logic        icache_ready_i, icache_rsp_valid_i;
   logic        icache_req_o, kill_s1_o, kill_s2_o, rsp_accept_o;
   logic [63:0] icache_vaddr_o;
   logic [1:0]  state_o;
   int          tests = 0, failed = 0;

   fetch_redirect_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .boot_addr_i(boot_addr_i),
      .ex_valid_i(ex_valid_i), .trap_vector_base_i(trap_vector_base_i),
      .eret_i(eret_i), .epc_i(epc_i),
      .mispredict_i(mispredict_i), .mispredict_target_i(mispredict_target_i),
      .replay_i(replay_i), .replay_addr_i(replay_addr_i),
      .bp_valid_i(bp_valid_i), .bp_target_i(bp_target_i),
      .halt_i(halt_i), .iq_ready_i(iq_ready_i), .icache_ready_i(icache_ready_i),
      .icache_rsp_valid_i(icache_rsp_valid_i), .icache_req_o(icache_req_o),
      .icache_vaddr_o(icache_vaddr_o), .kill_s1_o(kill_s1_o), .kill_s2_o(kill_s2_o),
      .rsp_accept_o(rsp_accept_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni = 1'b0;
      boot_addr_i = 64'h8000_0000; trap_vector_base_i = 64'h100; epc_i = 64'h200;
      mispredict_target_i = 64'h300; replay_addr_i = 64'h400; bp_target_i = 64'h8000_1000;
      ex_valid_i = 0; eret_i = 0; mispredict_i = 0; replay_i = 0; bp_valid_i = 0;
      halt_i = 0; iq_ready_i = 1; icache_ready_i = 1; icache_rsp_valid_i = 0;
      step(); step();
      chk("rst_state", state_o, 0);
      chk("rst_req", icache_req_o, 0);
      chk("rst_vaddr", icache_vaddr_o, 0);
      chk("rst_kills", {kill_s1_o, kill_s2_o, rsp_accept_o}, 0);
      rst_ni = 1'b1;
      #1;
      chk("boot_state", state_o, 0);
      chk("boot_req", icache_req_o, 0);
      step();
      chk("run_state", state_o, 1);
      chk("req0", icache_req_o, 1);
      chk("vaddr0", icache_vaddr_o, 64'h8000_0000);
      step();
      chk("req1", icache_req_o, 1);
      chk("vaddr1", icache_vaddr_o, 64'h8000_0004);
      step();
      chk("max_out_block", icache_req_o, 0);
      icache_rsp_valid_i = 1;
      #1;
      chk("rsp_acc", rsp_accept_o, 1);
      chk("still_blocked", icache_req_o, 0);
      step();
      icache_rsp_valid_i = 0;
      #1;
      chk("resume_req", icache_req_o, 1);
      chk("resume_vaddr", icache_vaddr_o, 64'h8000_0008);
      step();
      chk("full_again", icache_req_o, 0);
      ex_valid_i = 1; eret_i = 1; mispredict_i = 1;
      #1;
      chk("hard_kill", {kill_s1_o, kill_s2_o}, 2'b11);
      chk("hard_noreq", icache_req_o, 0);
      step();
      ex_valid_i = 0; eret_i = 0; mispredict_i = 0;
      icache_rsp_valid_i = 1;
      #1;
      chk("redir_state", state_o, 2);
      chk("redir_noreq", icache_req_o, 0);
      chk("redir_pc", icache_vaddr_o, 64'h100);
      chk("stale_rsp_redir", rsp_accept_o, 0);
      step();
      chk("stale_rsp_run", rsp_accept_o, 0);
      chk("post_redir_req", icache_req_o, 1);
      chk("post_redir_vaddr", icache_vaddr_o, 64'h100);
      step();
      icache_rsp_valid_i = 0;
      #1;
      chk("seq_vaddr", icache_vaddr_o, 64'h104);
      icache_rsp_valid_i = 1; bp_valid_i = 1;
      #1;
      chk("bp_acc", rsp_accept_o, 1);
      chk("bp_kills", {kill_s1_o, kill_s2_o}, 2'b01);
      chk("bp_suppress", icache_req_o, 0);
      step();
      icache_rsp_valid_i = 0; bp_valid_i = 0;
      #1;
      chk("bp_state", state_o, 1);
      chk("bp_req", icache_req_o, 1);
      chk("bp_vaddr", icache_vaddr_o, 64'h8000_1000);
      step();
      chk("bp_seq", icache_vaddr_o, 64'h8000_1004);
      step();
      halt_i = 1;
      #1;
      chk("halt_noreq", icache_req_o, 0);
      step();
      chk("halt_state", state_o, 3);
      icache_rsp_valid_i = 1;
      #1;
      chk("halt_drain1", rsp_accept_o, 1);
      step();
      chk("halt_drain2", rsp_accept_o, 1);
      step();
      chk("halt_drained", rsp_accept_o, 0);
      chk("halt_hold", state_o, 3);
      icache_rsp_valid_i = 0; halt_i = 0;
      #1;
      chk("halt_exit_noreq", icache_req_o, 0);
      step();
      chk("unhalt_state", state_o, 1);
      chk("unhalt_req", icache_req_o, 1);
      chk("unhalt_vaddr", icache_vaddr_o, 64'h8000_1008);
      bp_valid_i = 1;
      #1;
      chk("bp_no_rsp_kill", kill_s2_o, 0);
      chk("bp_no_rsp_req", icache_req_o, 1);
      step();
      bp_valid_i = 0;
      #1;
      chk("bp_ignored_vaddr", icache_vaddr_o, 64'h8000_100C);
      rst_ni = 0;
      #1;
      chk("async_rst_state", state_o, 0);
      chk("async_rst_vaddr", icache_vaddr_o, 0);
      chk("async_rst_req", icache_req_o, 0);
      step();
      rst_ni = 1; ex_valid_i = 1;
      #1;
      chk("boot_ignore_kill", {kill_s1_o, kill_s2_o}, 0);
      step();
      ex_valid_i = 0;
      #1;
      chk("boot_ignore_state", state_o, 1);
      chk("boot_ignore_vaddr", icache_vaddr_o, 64'h8000_0000);
      chk("boot_ignore_req", icache_req_o, 1);
      step();
      chk("reboot_seq", icache_vaddr_o, 64'h8000_0004);
      replay_i = 1;
      #1;
      chk("replay_kill", {kill_s1_o, kill_s2_o}, 2'b11);
      step();
      replay_i = 0; halt_i = 1;
      #1;
      chk("replay_pc", icache_vaddr_o, 64'h400);
      step();
      chk("redir_to_halt", state_o, 3);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
